// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix-multiply core.
//   state_e : controller states (IDLE -> LOAD -> COMPUTE -> DONE)
//   addr_w  : index width for a count of n items, never narrower than 1 bit
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_e;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Serial signed multiply-accumulate.
//   clk, rst : clock, asynchronous active-high reset
//   en       : update the accumulator this cycle
//   clr      : load the product instead of adding it (start of a dot product)
//   a, b     : signed operands (DATA_W, COEF_W)
//   acc      : registered accumulator
//   acc_nxt  : value acc takes on an enabled edge (used to write results without a bubble)
module matmul_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  acc_nxt
);

  localparam int unsigned PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod;
  logic        [ACC_W-1:0] prod_ext;

  assign prod = $signed(a) * $signed(b);
  // Signed source: widening sign-extends, narrowing keeps low bits (wraps).
  assign prod_ext = ACC_W'(prod);
  assign acc_nxt  = clr ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/matmul_seq_core.sv
// Sequential Y = X*C engine: streams in an M x K matrix X, multiplies by a K x N ROM matrix C
// with one MAC, buffers Y and serves addressed reads once done.
//   clk, rst            : clock, asynchronous active-high reset
//   start_in            : start pulse, honoured in IDLE or DONE
//   valid_input, x_data : X stream (row-major); x_ready high throughout LOAD
//   coef_addr           : ROM address k*N+j; coef_rdata returns one cycle later
//   read_n, r_addr      : active-low read strobe and Y address (i*N+j), served in DONE only
//   ry, data_out        : registered read response, one cycle after the strobe
//   busy, finish        : LOAD/COMPUTE indicator, DONE level
module matmul_seq_core
  import matmul_pkg::*;
#(
  parameter int unsigned M      = 4,
  parameter int unsigned K      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(K),
  localparam int unsigned X_AW  = addr_w(M * K),
  localparam int unsigned C_AW  = addr_w(K * N),
  localparam int unsigned Y_AW  = addr_w(M * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  output logic [C_AW-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_rdata,
  input  logic              read_n,
  input  logic [Y_AW-1:0]   r_addr,
  output logic              ry,
  output logic [ACC_W-1:0]  data_out,
  output logic              busy,
  output logic              finish
);

  localparam int unsigned IW = addr_w(M);
  localparam int unsigned JW = addr_w(N);
  localparam int unsigned KW = addr_w(K);
  localparam logic [IW-1:0]   I_LAST = IW'(M - 1);
  localparam logic [JW-1:0]   J_LAST = JW'(N - 1);
  localparam logic [KW-1:0]   K_LAST = KW'(K - 1);
  localparam logic [X_AW-1:0] X_LAST = X_AW'(M * K - 1);

  state_e state_q, state_d;

  logic [X_AW-1:0] ld_cnt_q;
  logic [IW-1:0]   i_q, i_p_q;
  logic [JW-1:0]   j_q, j_p_q;
  logic [KW-1:0]   k_q, k_p_q;
  logic            drain_q;
  logic            issue_p_q;   // a coefficient issued last cycle is on coef_rdata now
  logic            ry_q;
  logic [ACC_W-1:0] data_out_q;

  logic [DATA_W-1:0] x_mem [M*K];
  logic [ACC_W-1:0]  y_mem [M*N];

  logic             accept, last_beat, issue, last_issue, y_we;
  logic [X_AW-1:0]  x_rd_idx;
  logic [Y_AW-1:0]  y_wr_idx;
  logic [ACC_W-1:0] acc, acc_nxt;

  assign accept     = (state_q == LOAD) && valid_input;
  assign last_beat  = accept && (ld_cnt_q == X_LAST);
  assign issue      = (state_q == COMPUTE) && !drain_q;
  assign last_issue = issue && (i_q == I_LAST) && (j_q == J_LAST) && (k_q == K_LAST);
  assign y_we       = issue_p_q && (k_p_q == K_LAST);
  assign x_rd_idx   = X_AW'(i_p_q * K + k_p_q);
  assign y_wr_idx   = Y_AW'(i_p_q * N + j_p_q);

  assign x_ready   = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == COMPUTE);
  assign finish    = (state_q == DONE);
  // Counters idle at zero outside COMPUTE, so the address also rests at zero.
  assign coef_addr = C_AW'(k_q * N + j_q);
  assign ry        = ry_q;
  assign data_out  = data_out_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = LOAD;
      LOAD:    if (last_beat) state_d = COMPUTE;
      COMPUTE: if (drain_q) state_d = DONE;
      DONE:    if (start_in) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      i_p_q      <= '0;
      j_p_q      <= '0;
      k_p_q      <= '0;
      drain_q    <= 1'b0;
      issue_p_q  <= 1'b0;
      ry_q       <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ld_cnt_q <= last_beat ? '0 : ld_cnt_q + 1'b1;
      drain_q   <= last_issue;
      issue_p_q <= issue;
      i_p_q     <= i_q;
      j_p_q     <= j_q;
      k_p_q     <= k_q;
      if (issue) begin
        if (k_q == K_LAST) begin
          k_q <= '0;
          if (j_q == J_LAST) begin
            j_q <= '0;
            i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
      if ((state_q == DONE) && !read_n) begin
        ry_q       <= 1'b1;
        data_out_q <= (32'(r_addr) < M * N) ? y_mem[r_addr] : '0;
      end else begin
        ry_q <= 1'b0;
      end
    end
  end

  // Storage arrays carry no reset; their contents are only observable after a full run.
  always_ff @(posedge clk) begin
    if (accept) x_mem[ld_cnt_q] <= x_data;
    if (y_we)   y_mem[y_wr_idx] <= acc_nxt;
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en      (issue_p_q),
    .clr     (k_p_q == '0),
    .a       (x_mem[x_rd_idx]),
    .b       (coef_rdata),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

endmodule

// File: tb/tb_matmul_seq_core.sv
// Self-checking bench for matmul_seq_core: default 4x4x4 instance plus a 3x2x3 instance for
// out-of-range reads.
module tb_matmul_seq_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_in, valid_input, read_n;
  logic [7:0]  x_data, coef_rdata;
  logic [3:0]  coef_addr, r_addr;
  logic        x_ready, ry, busy, finish;
  logic [17:0] data_out;

  logic        start2, valid2, read_n2, x_ready2, ry2, busy2, finish2;
  logic [7:0]  x_data2;
  logic [7:0]  coef_rdata2;
  logic [2:0]  coef_addr2;
  logic [3:0]  r_addr2;
  logic [16:0] data_out2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [7:0]  x_vec [16];
  logic [7:0]  c_rom [16];
  logic [17:0] y_exp [16];

  typedef struct {logic [17:0] val; int t;} sb_t;
  sb_t sb[$];

  typedef struct {logic [3:0] addr; logic [17:0] exp;} vec_t;
  vec_t tbl [16];

  matmul_seq_core dut (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start_in),
    .valid_input (valid_input),
    .x_data      (x_data),
    .x_ready     (x_ready),
    .coef_addr   (coef_addr),
    .coef_rdata  (coef_rdata),
    .read_n      (read_n),
    .r_addr      (r_addr),
    .ry          (ry),
    .data_out    (data_out),
    .busy        (busy),
    .finish      (finish)
  );

  matmul_seq_core #(.M(3), .K(2), .N(3)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start2),
    .valid_input (valid2),
    .x_data      (x_data2),
    .x_ready     (x_ready2),
    .coef_addr   (coef_addr2),
    .coef_rdata  (coef_rdata2),
    .read_n      (read_n2),
    .r_addr      (r_addr2),
    .ry          (ry2),
    .data_out    (data_out2),
    .busy        (busy2),
    .finish      (finish2)
  );

  assign coef_rdata2 = 8'd1;  // all-ones C for the small instance

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) coef_rdata <= c_rom[coef_addr];

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Read-response scoreboard: every ry pops one expected entry.
  always @(negedge clk) begin
    sb_t e;
    if (ry) begin
      if (sb.size() == 0) begin
        chk(1'b0, "spurious_ry", 1, 0);
      end else begin
        e = sb.pop_front();
        chk(data_out == e.val, "rd_data", data_out, e.val);
        chk(cyc == e.t + 1, "rd_latency", cyc, e.t + 1);
      end
    end
  end

  function automatic void model();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += $signed(x_vec[i*4+k]) * $signed(c_rom[k*4+j]);
        y_exp[i*4+j] = s[17:0];
      end
    end
  endfunction

  task automatic load_x(input bit do_start, input bit toggle, output int t);
    int idx;
    idx = 0;
    t = 0;
    if (do_start) begin
      @(negedge clk);
      start_in = 1'b1;
    end
    for (int n = 0; n < 100 && idx < 16; n++) begin
      @(negedge clk);
      start_in    = 1'b0;
      valid_input = !toggle || (n % 2 == 0);
      x_data      = x_vec[idx];
      if (valid_input && x_ready) begin
        t = cyc;
        idx++;
      end
    end
    chk(idx == 16, "load_beats", idx, 16);
    @(negedge clk);
    valid_input = 1'b0;
    chk(!x_ready && busy, "compute_entry", {x_ready, busy}, 1);
  endtask

  task automatic wait_finish(input int t, input string nm);
    int f;
    f = -1;
    for (int n = 0; n < 300 && f < 0; n++) begin
      @(negedge clk);
      if (finish) f = cyc;
    end
    chk(f == t + 66, nm, f, t + 66);
  endtask

  task automatic rd(input logic [3:0] a, input bit st, input logic [17:0] v);
    @(negedge clk);
    read_n   = 1'b0;
    r_addr   = a;
    start_in = st;
    sb.push_back('{val: v, t: cyc});
  endtask

  task automatic rd_end();
    @(negedge clk);
    read_n   = 1'b1;
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    chk(sb.size() == 0, "sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int idx;
    logic [3:0]  a2 [5];
    logic [16:0] e2 [5];

    rst = 1'b1; start_in = 1'b0; valid_input = 1'b0; x_data = '0; read_n = 1'b1; r_addr = '0;
    start2 = 1'b0; valid2 = 1'b0; x_data2 = '0; read_n2 = 1'b1; r_addr2 = '0;
    for (int a = 0; a < 16; a++) c_rom[a] = '0;
    repeat (2) @(negedge clk);
    chk({x_ready, busy, finish, ry, coef_addr, data_out} == '0, "reset_outputs",
        {x_ready, busy, finish, ry, coef_addr, data_out}, 0);
    rst = 1'b0;

    // Read attempt in IDLE is ignored.
    @(negedge clk);
    read_n = 1'b0; r_addr = 4'd3;
    @(negedge clk);
    chk(!ry && data_out == '0, "idle_read", {ry, data_out}, 0);
    read_n = 1'b1;

    // Identity C, X = 1..16: Y[a] = a+1. Table read back in reverse order.
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) c_rom[k*4+j] = (k == j) ? 8'd1 : 8'd0;
    for (int a = 0; a < 16; a++) x_vec[a] = 8'(a + 1);
    for (int n = 0; n < 16; n++) tbl[n] = '{addr: 4'(15 - n), exp: 18'(16 - n)};
    load_x(1'b1, 1'b0, t);
    wait_finish(t, "finish_identity");
    for (int n = 0; n < 16; n++) rd(tbl[n].addr, 1'b0, tbl[n].exp);
    // Read together with start: read served, state goes to LOAD.
    rd(4'd5, 1'b1, 18'd6);
    @(negedge clk);
    read_n = 1'b1; start_in = 1'b0;
    chk(!finish && busy && x_ready, "read_with_start", {finish, busy, x_ready}, 3);
    @(negedge clk);
    chk(sb.size() == 0, "sb_empty", sb.size(), 0);

    // All -128: every Y = 65536, no wrap at 18 bits.
    for (int a = 0; a < 16; a++) begin x_vec[a] = 8'h80; c_rom[a] = 8'h80; end
    load_x(1'b0, 1'b0, t);
    wait_finish(t, "finish_neg128");
    for (int a = 0; a < 16; a++) rd(4'(a), 1'b0, 18'd65536);
    rd_end();

    // Random data, valid toggled, start pulsed mid-COMPUTE.
    for (int a = 0; a < 16; a++) begin x_vec[a] = 8'($urandom); c_rom[a] = 8'($urandom); end
    model();
    load_x(1'b1, 1'b1, t);
    repeat (30) @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_finish(t, "finish_start_ignored");
    for (int a = 0; a < 16; a++) rd(4'(a), 1'b0, y_exp[a]);
    rd_end();

    // Reset mid-COMPUTE, then a fresh run.
    for (int a = 0; a < 16; a++) begin x_vec[a] = 8'($urandom); c_rom[a] = 8'($urandom); end
    model();
    load_x(1'b1, 1'b0, t);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk({x_ready, busy, finish, ry, coef_addr, data_out} == '0, "async_reset",
           {x_ready, busy, finish, ry, coef_addr, data_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    load_x(1'b1, 1'b0, t);
    wait_finish(t, "finish_after_reset");
    for (int a = 15; a >= 0; a--) rd(4'(a), 1'b0, y_exp[a]);
    rd_end();

    // 3x2x3 instance, X = 1..6, C all ones: Y row sums 3, 7, 11; addresses 9..15 out of range.
    @(negedge clk);
    start2 = 1'b1;
    idx = 0;
    for (int n = 0; n < 40 && idx < 6; n++) begin
      @(negedge clk);
      start2  = 1'b0;
      valid2  = 1'b1;
      x_data2 = 8'(idx + 1);
      if (x_ready2) idx++;
    end
    @(negedge clk);
    valid2 = 1'b0;
    for (int n = 0; n < 100 && !finish2; n++) @(negedge clk);
    chk(finish2, "dut2_finish", finish2, 1);
    a2 = '{4'd4, 4'd9, 4'd8, 4'd15, 4'd0};
    e2 = '{17'd7, 17'd0, 17'd11, 17'd0, 17'd3};
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      read_n2 = 1'b0; r_addr2 = a2[n];
      @(negedge clk);
      read_n2 = 1'b1;
      chk(ry2 && data_out2 == e2[n], "dut2_read", {ry2, data_out2}, {1'b1, e2[n]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
